// File: rtl/md_pipe_add3.sv
// md_pipe_add3: two-stage pipelined three-operand adder, result = (a + b) + d.
// Valid/ready handshakes on both sides. A stage moves whenever the stage
// after it is free, so the pipe runs at one result per cycle with no bubbles.
// res_cnt counts results handed to the consumer and wraps silently.
// Optional feature macro: MD_PIPE_ADD3_SAT_EN. When it is defined, stage 2
// clamps the result to 2^WIDTH-1 and flags the clamp on out_ovf.
module md_pipe_add3 #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] out_sum,
  output logic             out_ovf,
  output logic [CNT_W-1:0] res_cnt
);

  logic             s1_valid;
  logic [WIDTH:0]   s1_sum;
  logic [WIDTH-1:0] s1_d;

  logic             st2_free;
  logic             s1_move;
  logic             accept;
  logic             handoff;
  logic [WIDTH+1:0] full_sum;
  logic [WIDTH+1:0] st2_sum;
  logic             st2_ovf;

  assign st2_free = !out_valid || out_ready;
  assign s1_move  = s1_valid && st2_free;
  assign in_ready = !s1_valid || st2_free;
  assign accept   = in_valid && in_ready;
  assign handoff  = out_valid && out_ready;

  // The full sum can never exceed 3*(2^WIDTH-1), so WIDTH+2 bits always hold it.
  assign full_sum = {1'b0, s1_sum} + {2'b00, s1_d};

`ifdef MD_PIPE_ADD3_SAT_EN
  localparam logic [WIDTH+1:0] SAT_MAX = {2'b00, {WIDTH{1'b1}}};

  // Clamp anything above the largest WIDTH-bit value and flag it.
  always_comb begin
    st2_sum = full_sum;
    st2_ovf = 1'b0;
    if (full_sum > SAT_MAX) begin
      st2_sum = SAT_MAX;
      st2_ovf = 1'b1;
    end
  end

  // The overflow flag travels with its result and holds while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_ovf <= 1'b0;
    end else if (s1_move) begin
      out_ovf <= st2_ovf;
    end
  end
`else
  assign st2_sum = full_sum;
  assign st2_ovf = 1'b0;
  assign out_ovf = st2_ovf;
`endif

  // Stage 1 captures a + b together with d on every accepted beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_d     <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_sum   <= {1'b0, in_a} + {1'b0, in_b};
      s1_d     <= in_d;
    end else if (s1_move) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2 holds the result until the consumer takes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
    end else if (s1_move) begin
      out_valid <= 1'b1;
      out_sum   <= st2_sum;
    end else if (handoff) begin
      out_valid <= 1'b0;
    end
  end

  // Count every result handed off; wrapping past the top is intentional.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_cnt <= '0;
    end else if (handoff) begin
      res_cnt <= res_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_md_pipe_add3.sv
// Testbench for md_pipe_add3 (WIDTH=4, CNT_W=2). A scoreboard queue receives
// the model result at each accept and is popped at each hand-off.
module tb_md_pipe_add3;

  localparam int WIDTH = 4;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_d;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH+1:0] out_sum;
  logic             out_ovf;
  logic [CNT_W-1:0] res_cnt;

  int tests_run = 0;
  int fails = 0;

  logic [6:0] sb[$];
  logic [6:0] exp_res;
  int         exp_cnt = 0;

  logic       acc;
  logic       hand;
  logic [5:0] obs_sum;
  logic       obs_ovf;

  md_pipe_add3 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .in_d(in_d),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum(out_sum),
    .out_ovf(out_ovf),
    .res_cnt(res_cnt)
  );

  always #5 clk = ~clk;

  // Reference result: {ovf, sum}.
  function automatic logic [6:0] model(input int a, input int b, input int d);
    int full;
    full = a + b + d;
`ifdef MD_PIPE_ADD3_SAT_EN
    if (full > 15) return {1'b1, 6'd15};
`endif
    return {1'b0, 6'(full)};
  endfunction

  // Advance one cycle. Handshakes are sampled on the falling edge, before the
  // rising edge they act on. Returns 1 ns after the rising edge.
  task automatic tick();
    @(negedge clk);
    acc     = rst_n && in_valid && in_ready;
    hand    = rst_n && out_valid && out_ready;
    obs_sum = out_sum;
    obs_ovf = out_ovf;
    if (acc) sb.push_back(model(int'(in_a), int'(in_b), int'(in_d)));
    if (hand) exp_cnt = (exp_cnt + 1) % 4;
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int a, input int b, input int d);
    in_valid = 1'b1;
    in_a = 4'(a);
    in_b = 4'(b);
    in_d = 4'(d);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_d = '0;
    out_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    sb.delete();
    exp_cnt = 0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_sum !== 6'd0 || res_cnt !== 2'd0 || in_ready !== 1'b1 || out_ovf !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_state: got valid=%b sum=%0d cnt=%0d rdy=%b ovf=%b, want 0 0 0 1 0",
               out_valid, out_sum, res_cnt, in_ready, out_ovf);
    end
  endtask

  task automatic test_single_beat();
    out_ready = 1'b1;
    set_beat(3, 5, 7);
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (acc !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL single_latency1: got acc=%b valid=%b, want acc=1 valid=0", acc, out_valid);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_sum !== 6'd15) begin
      fails++;
      $display("[TB] FAIL single_result: got valid=%b sum=%0d, want valid=1 sum=15", out_valid, out_sum);
    end
    tick();
    tests_run++;
    if (!hand || sb.size() == 0) begin
      fails++;
      $display("[TB] FAIL single_handoff: got hand=%b queued=%0d, want hand=1 queued=1", hand, sb.size());
    end else begin
      exp_res = sb.pop_front();
      if (obs_sum !== exp_res[5:0] || obs_ovf !== exp_res[6]) begin
        fails++;
        $display("[TB] FAIL single_sb: got sum=%0d ovf=%b, want sum=%0d ovf=%b", obs_sum, obs_ovf, exp_res[5:0], exp_res[6]);
      end
    end
    tests_run++;
    if (out_valid !== 1'b0 || res_cnt !== 2'(exp_cnt) || exp_cnt != 1) begin
      fails++;
      $display("[TB] FAIL single_after: got valid=%b cnt=%0d, want valid=0 cnt=1", out_valid, res_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int first_hand;
    int last_hand;
    int nhand;
    out_ready = 1'b1;
    set_beat(15, 15, 15);
    tick();
    tests_run++;
    if (acc !== 1'b1) begin
      fails++;
      $display("[TB] FAIL b2b_accept1: got acc=%b, want 1", acc);
    end
    set_beat(1, 2, 3);
    tick();
    tests_run++;
    if (acc !== 1'b1) begin
      fails++;
      $display("[TB] FAIL b2b_accept2: got acc=%b, want 1", acc);
    end
    in_valid = 1'b0;
    first_hand = -1;
    last_hand = -1;
    nhand = 0;
    for (int c = 0; c < 20 && sb.size() > 0; c++) begin
      tick();
      if (hand) begin
        if (first_hand < 0) first_hand = c;
        last_hand = c;
        nhand++;
        exp_res = sb.pop_front();
        tests_run++;
        if (obs_sum !== exp_res[5:0] || obs_ovf !== exp_res[6]) begin
          fails++;
          $display("[TB] FAIL b2b_result: got sum=%0d ovf=%b, want sum=%0d ovf=%b", obs_sum, obs_ovf, exp_res[5:0], exp_res[6]);
        end
      end
    end
    tests_run++;
    if (sb.size() != 0 || nhand != 2 || last_hand - first_hand != 1) begin
      fails++;
      $display("[TB] FAIL b2b_timing: got handoffs=%0d gap=%0d left=%0d, want 2 1 0", nhand, last_hand - first_hand, sb.size());
      sb.delete();
    end
    tests_run++;
    if (res_cnt !== 2'(exp_cnt) || exp_cnt != 3) begin
      fails++;
      $display("[TB] FAIL b2b_count: got cnt=%0d, want 3", res_cnt);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    set_beat(1, 1, 1);
    tick();
    set_beat(2, 2, 2);
    tick();
    set_beat(4, 4, 4);
    tick();
    tests_run++;
    if (acc !== 1'b0 || in_ready !== 1'b0 || sb.size() != 2) begin
      fails++;
      $display("[TB] FAIL bp_full: got acc=%b rdy=%b queued=%0d, want 0 0 2", acc, in_ready, sb.size());
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || out_sum !== 6'd3 || acc !== 1'b0) begin
        fails++;
        $display("[TB] FAIL bp_hold: got valid=%b sum=%0d acc=%b, want 1 3 0", out_valid, out_sum, acc);
      end
    end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && (in_valid || sb.size() > 0); c++) begin
      tick();
      if (acc) in_valid = 1'b0;
      if (hand) begin
        tests_run++;
        if (sb.size() == 0) begin
          fails++;
          $display("[TB] FAIL bp_extra: got unexpected sum=%0d, want none", obs_sum);
        end else begin
          exp_res = sb.pop_front();
          if (obs_sum !== exp_res[5:0] || obs_ovf !== exp_res[6]) begin
            fails++;
            $display("[TB] FAIL bp_result: got sum=%0d ovf=%b, want sum=%0d ovf=%b", obs_sum, obs_ovf, exp_res[5:0], exp_res[6]);
          end
        end
      end
    end
    tests_run++;
    if (sb.size() != 0 || in_valid !== 1'b0 || res_cnt !== 2'(exp_cnt) || exp_cnt != 2) begin
      fails++;
      $display("[TB] FAIL bp_drain: got left=%0d pending=%b cnt=%0d, want 0 0 2", sb.size(), in_valid, res_cnt);
      sb.delete();
      in_valid = 1'b0;
    end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    set_beat(5, 6, 7);
    tick();
    set_beat(1, 1, 1);
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sb.delete();
    exp_cnt = 0;
    tests_run++;
    if (out_valid !== 1'b0 || res_cnt !== 2'd0 || out_sum !== 6'd0) begin
      fails++;
      $display("[TB] FAIL mid_reset: got valid=%b cnt=%0d sum=%0d, want 0 0 0", out_valid, res_cnt, out_sum);
    end
    out_ready = 1'b1;
    set_beat(0, 0, 1);
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 20 && sb.size() > 0; c++) begin
      tick();
      if (hand) begin
        exp_res = sb.pop_front();
        tests_run++;
        if (obs_sum !== exp_res[5:0] || obs_sum !== 6'd1) begin
          fails++;
          $display("[TB] FAIL mid_reset_result: got sum=%0d, want sum=1", obs_sum);
        end
      end
    end
    tests_run++;
    if (sb.size() != 0 || res_cnt !== 2'd1) begin
      fails++;
      $display("[TB] FAIL mid_reset_after: got left=%0d cnt=%0d, want 0 1", sb.size(), res_cnt);
      sb.delete();
    end
  endtask

  task automatic test_counter_wrap();
    int seq[5];
    int sent;
    int k;
    seq = '{1, 2, 3, 0, 1};
    rst_n = 1'b0;
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    sb.delete();
    exp_cnt = 0;
    out_ready = 1'b1;
    sent = 0;
    k = 0;
    for (int c = 0; c < 40 && (sent < 5 || sb.size() > 0); c++) begin
      if (sent < 5) set_beat(sent, 1, 2);
      else in_valid = 1'b0;
      tick();
      if (acc) sent++;
      if (hand && k < 5) begin
        exp_res = sb.pop_front();
        tests_run++;
        if (obs_sum !== exp_res[5:0] || res_cnt !== 2'(seq[k])) begin
          fails++;
          $display("[TB] FAIL wrap_%0d: got sum=%0d cnt=%0d, want sum=%0d cnt=%0d", k, obs_sum, res_cnt, exp_res[5:0], seq[k]);
        end
        k++;
      end
    end
    in_valid = 1'b0;
    tests_run++;
    if (k != 5 || sb.size() != 0) begin
      fails++;
      $display("[TB] FAIL wrap_total: got handoffs=%0d left=%0d, want 5 0", k, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_back_to_back();
    test_backpressure();
    test_mid_reset();
    test_counter_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/md_pipe_add3.md
Name: md_pipe_add3

Overview:
- Parametrised two-stage pipelined three-operand adder: result = (a + b) + d.
- Adds valid/ready flow control, back-pressure, a completed-result counter and synchronous reset.
- Sits between an operand source and a result consumer; replaces the fixed 1-bit, free-running two-stage add in the lab datapath.
- All operands of one transaction travel together in a single beat.

Parameters:
- WIDTH, 8, width of each unsigned operand a, b, d (WIDTH >= 1).
- CNT_W, 16, width of the completed-result counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts beat this cycle.
- in_a  input  WIDTH  operand a.
- in_b  input  WIDTH  operand b.
- in_d  input  WIDTH  operand d.
- out_valid  output  1  result present.
- out_ready  input  1  consumer takes result this cycle.
- out_sum  output  WIDTH+2  result.
- out_ovf  output  1  saturation occurred for this result (optional feature only).
- res_cnt  output  CNT_W  number of results handed off.

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a posedge):
  - s1_valid=0, out_valid=0, out_sum=0, out_ovf=0, res_cnt=0.
  - in_ready may be high during reset, but no beat is captured while rst_n=0.
- Handshakes:
  - Accept when in_valid && in_ready.
  - Hand-off when out_valid && out_ready.
  - Operands sampled only on accept.
- Stage 1 (register s1):
  - On accept, s1_sum <= in_a + in_b at WIDTH+1 bits, zero-extended, no truncation.
  - Also s1_d <= in_d and s1_valid <= 1.
- Stage 2 (output register):
  - out_sum <= s1_sum + s1_d at WIDTH+2 bits; out_valid <= 1.
  - Max value 3*(2^WIDTH-1) always fits.
- Advance rules (standard pipeline, no bubbles):
  - st2_free = !out_valid || out_ready.
  - s1 moves to stage 2 when s1_valid && st2_free.
  - in_ready = !s1_valid || st2_free, combinational from state and out_ready.
- Register updates:
  - out_valid clears on hand-off when no new s1 data moves in.
  - s1_valid clears when s1 moves and no new accept occurs.
  - Simultaneous hand-off + s1 move + accept all occur in the same cycle → sustained 1 result/cycle.
- Latency: accept at edge N → out_valid=1 after edge N+1 (result visible in cycle N+1, 2 registers), provided no stall.
- Stall: out_ready=0 with out_valid=1:
  - out_sum/out_ovf hold stable.
  - s1 may still fill once; then in_ready=0.
  - Maximum in-flight count is 2; no beat is dropped or duplicated.
- Empty pipeline: out_valid=0; out_sum holds its last value (don't-care to consumer).
- Counter:
  - res_cnt increments by 1 per hand-off and wraps 2^CNT_W-1 → 0 silently.
  - Updated at the hand-off edge.
- Reset mid-operation: all in-flight beats discarded; counter cleared; first accept after rst_n returns high behaves as from idle.
- out_valid must never drop without a hand-off (except via reset); out_sum must not change while out_valid && !out_ready.

Optional Feature:
- Macro: MD_PIPE_ADD3_SAT_EN.
- Defined:
  - Stage 2 clamps the result to 2^WIDTH-1 when the full sum exceeds it; upper 2 bits of out_sum are then 0.
  - out_ovf=1 registered alongside that result, else 0.
  - out_ovf obeys the same hold and reset rules as out_sum.
- Undefined: full-width WIDTH+2 result; out_ovf tied 0; no clamp logic synthesised.

Test Plan:
- WIDTH=4, reset 3 cycles then idle → out_valid=0, out_sum=0, res_cnt=0, in_ready=1.
- Single beat a=3,b=5,d=7, out_ready=1 → out_valid=1 with out_sum=15 one cycle after accept edge, for exactly 1 cycle; res_cnt=1.
- Back-to-back a=b=d=15 then a=1,b=2,d=3, out_ready=1 → consecutive results 45 (0x2D) then 6; in_ready stays 1; res_cnt=2.
  - With MD_PIPE_ADD3_SAT_EN: 15 with out_ovf=1, then 6 with out_ovf=0.
- Back-pressure: out_ready=0, 3 beats offered (1,1,1),(2,2,2),(4,4,4) → first two accepted, in_ready=0 for third; out_sum=3 stable.
  - Then out_ready=1 → results 3, 6, 12 in order, none lost.
- Reset mid-operation: 2 beats in flight, rst_n=0 one cycle → out_valid=0, res_cnt=0 next cycle; subsequent beat 0,0,1 → out_sum=1.
- Counter wrap with CNT_W=2: 5 hand-offs → res_cnt sequence 1,2,3,0,1.
